// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the external memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  typedef enum logic [1:0] {OWN_IC, OWN_DCR, OWN_DCW} owner_t;

  localparam logic ISIDE  = 1'b0;
  localparam logic DSIDE  = 1'b1;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises I-cache refills and D-cache refill/write-back line transactions
// onto the single external memory port, round-robin between I- and D-side.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int OFF_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_read_req,
  input  logic [ADDR_W-1:0] ic_read_addr,
  output logic              ic_read_ack,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_read_req,
  input  logic [ADDR_W-1:0] dc_read_addr,
  output logic              dc_read_ack,
  output logic [LINE_W-1:0] dc_read_data,
  input  logic              dc_write_req,
  input  logic [ADDR_W-1:0] dc_write_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_write_ack,
  output logic              mem_enable,
  output logic              mem_rw,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_data_in,
  output logic [LINE_W-1:0] mem_data_out
);

  state_t              state_reg, state_next;
  owner_t              owner_reg, owner_next;
  logic                last_grant_reg, last_grant_next;

  logic                mem_enable_next, mem_rw_next;
  logic [ADDR_W-1:0]   mem_addr_next;
  logic [LINE_W-1:0]   mem_data_out_next;
  logic                ic_read_ack_next, dc_read_ack_next, dc_write_ack_next;
  logic [LINE_W-1:0]   ic_read_data_next, dc_read_data_next;

  logic                any_req, grant_d;
  owner_t              win_owner;
  logic [ADDR_W-1:0]   win_addr;
  logic [LINE_W-1:0]   win_wdata;
  logic                win_rw;

  assign any_req = ic_read_req | dc_read_req | dc_write_req;

  // Winner selection: D-side evicts before refilling; on an I/D tie the side
  // that was not granted last time wins.
  always_comb begin
    grant_d   = 1'b0;
    win_owner = OWN_IC;
    win_addr  = ic_read_addr;
    win_wdata = '0;
    win_rw    = MEM_RD;
    if ((dc_write_req || dc_read_req) &&
        (!ic_read_req || last_grant_reg == ISIDE)) begin
      grant_d = 1'b1;
      if (dc_write_req) begin
        win_owner = OWN_DCW;
        win_addr  = dc_write_addr;
        win_wdata = dc_write_data;
        win_rw    = MEM_WR;
      end else begin
        win_owner = OWN_DCR;
        win_addr  = dc_read_addr;
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    owner_next        = owner_reg;
    last_grant_next   = last_grant_reg;
    mem_enable_next   = mem_enable;
    mem_rw_next       = mem_rw;
    mem_addr_next     = mem_addr;
    mem_data_out_next = mem_data_out;
    ic_read_ack_next  = 1'b0;
    dc_read_ack_next  = 1'b0;
    dc_write_ack_next = 1'b0;
    ic_read_data_next = ic_read_data;
    dc_read_data_next = dc_read_data;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next        = MEM;
          owner_next        = win_owner;
          last_grant_next   = grant_d ? DSIDE : ISIDE;
          mem_enable_next   = 1'b1;
          mem_rw_next       = win_rw;
          mem_addr_next     = {win_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          mem_data_out_next = win_wdata;
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_next      = RESP;
          mem_enable_next = 1'b0;
          case (owner_reg)
            OWN_IC: begin
              ic_read_ack_next  = 1'b1;
              ic_read_data_next = mem_data_in;
            end
            OWN_DCR: begin
              dc_read_ack_next  = 1'b1;
              dc_read_data_next = mem_data_in;
            end
            OWN_DCW: dc_write_ack_next = 1'b1;
            default: ;
          endcase
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_IC;
      last_grant_reg <= DSIDE;
      mem_enable     <= 1'b0;
      mem_rw         <= MEM_RD;
      mem_addr       <= '0;
      mem_data_out   <= '0;
      ic_read_ack    <= 1'b0;
      dc_read_ack    <= 1'b0;
      dc_write_ack   <= 1'b0;
      ic_read_data   <= '0;
      dc_read_data   <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      mem_enable     <= mem_enable_next;
      mem_rw         <= mem_rw_next;
      mem_addr       <= mem_addr_next;
      mem_data_out   <= mem_data_out_next;
      ic_read_ack    <= ic_read_ack_next;
      dc_read_ack    <= dc_read_ack_next;
      dc_write_ack   <= dc_write_ack_next;
      ic_read_data   <= ic_read_data_next;
      dc_read_data   <= dc_read_data_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences and
// randomized traffic against a request-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_read_req, dc_read_req, dc_write_req;
  logic [31:0]  ic_read_addr, dc_read_addr, dc_write_addr;
  logic [127:0] dc_write_data;
  logic         ic_read_ack, dc_read_ack, dc_write_ack;
  logic [127:0] ic_read_data, dc_read_data;
  logic         mem_enable, mem_rw, mem_ack;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data_in, mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .OFF_W(4)) dut (
    .clk(clk), .reset(reset),
    .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
    .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
    .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
    .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
    .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
    .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         ic, dcr, dcw;
    logic [31:0]  ic_a, dcr_a, dcw_a;
    logic [127:0] wdata, rdata;
    int           lat;
    owner_t       own;
    logic [31:0]  exp_a;
    logic         exp_rw;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full line transaction from an IDLE cycle with requests already driven.
  task automatic do_txn(input string nm, input owner_t own, input logic [31:0] exp_a,
                        input logic exp_rw, input logic [127:0] exp_wd,
                        input logic [127:0] rdata, input int lat);
    int   w;
    logic stable;
    logic [2:0] exp_acks;
    w = 1;
    tick();
    while (!mem_enable && w < 20) begin
      tick();
      w++;
    end
    check({nm, " enable"}, 128'(mem_enable), 128'(1));
    if (!mem_enable) return;
    check({nm, " grant_latency"}, 128'(w), 128'(1));
    check({nm, " addr"}, 128'(mem_addr), 128'(exp_a));
    check({nm, " rw"}, 128'(mem_rw), 128'(exp_rw));
    check({nm, " wdata"}, mem_data_out, exp_rw ? exp_wd : 128'(0));
    stable = 1'b1;
    repeat (lat) begin
      tick();
      if (!mem_enable || mem_addr !== exp_a || mem_rw !== exp_rw ||
          ic_read_ack || dc_read_ack || dc_write_ack) stable = 1'b0;
    end
    check({nm, " mem_stable"}, 128'(stable), 128'(1));
    mem_ack = 1'b1;
    mem_data_in = rdata;
    tick();
    mem_ack = 1'b0;
    mem_data_in = {$urandom, $urandom, $urandom, $urandom};
    exp_acks = (own == OWN_IC) ? 3'b100 : (own == OWN_DCR) ? 3'b010 : 3'b001;
    check({nm, " acks"}, 128'({ic_read_ack, dc_read_ack, dc_write_ack}), 128'(exp_acks));
    check({nm, " enable_drop"}, 128'(mem_enable), 128'(0));
    if (own == OWN_IC)  check({nm, " rdata"}, ic_read_data, rdata);
    if (own == OWN_DCR) check({nm, " rdata"}, dc_read_data, rdata);
    case (own)
      OWN_IC:  ic_read_req  = 1'b0;
      OWN_DCR: dc_read_req  = 1'b0;
      default: dc_write_req = 1'b0;
    endcase
    tick();
    check({nm, " acks_clear"}, 128'({ic_read_ack, dc_read_ack, dc_write_ack, mem_enable}), 128'(0));
    $display("[TB] %s owner=%0d addr=%h rw=%0d lat=%0d", nm, own, exp_a, exp_rw, lat);
  endtask

  function automatic vec_t mk(input logic ic, input logic dcr, input logic dcw,
                              input logic [31:0] ia, input logic [31:0] ra,
                              input logic [31:0] wa, input logic [127:0] wd,
                              input logic [127:0] rd, input int lat, input owner_t own,
                              input logic [31:0] ea, input logic erw);
    vec_t v;
    v.ic = ic; v.dcr = dcr; v.dcw = dcw;
    v.ic_a = ia; v.dcr_a = ra; v.dcw_a = wa;
    v.wdata = wd; v.rdata = rd; v.lat = lat;
    v.own = own; v.exp_a = ea; v.exp_rw = erw;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    logic [127:0] w1, w2, held;
    bit           ic_p, dcr_p, dcw_p, last_d, pick_d;
    logic [31:0]  ia, ra, wa, ea;
    logic [127:0] wd, rd;
    owner_t       own;

    w1 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
    w2 = 128'hFEED_FACE_CAFE_BABE_1234_5678_9ABC_DEF0;
    vecs[0]  = mk(1,1,1, 32'h1234, 32'h200, 32'h100, w1,
                  128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233, 3, OWN_IC, 32'h1230, 0);
    vecs[1]  = mk(0,1,1, 32'h1234, 32'h200, 32'h100, w1, {4{32'h1111_0001}}, 2, OWN_DCW, 32'h100, 1);
    vecs[2]  = mk(0,1,0, 32'h1234, 32'h200, 32'h100, w1, {4{32'h2222_0002}}, 1, OWN_DCR, 32'h200, 0);
    vecs[3]  = mk(1,1,0, 32'h3008, 32'h4010, 32'h100, w1, {4{32'h3333_0003}}, 1, OWN_IC,  32'h3000, 0);
    vecs[4]  = mk(1,1,0, 32'h5004, 32'h4010, 32'h100, w1, {4{32'h4444_0004}}, 1, OWN_DCR, 32'h4010, 0);
    vecs[5]  = mk(1,1,0, 32'h5004, 32'h6020, 32'h100, w1, {4{32'h5555_0005}}, 1, OWN_IC,  32'h5000, 0);
    vecs[6]  = mk(1,1,0, 32'h7000, 32'h6020, 32'h100, w1, {4{32'h6666_0006}}, 1, OWN_DCR, 32'h6020, 0);
    vecs[7]  = mk(1,0,1, 32'h8888, 32'h6020, 32'h9999, w2, {4{32'h7777_0007}}, 2, OWN_IC,  32'h8880, 0);
    vecs[8]  = mk(1,0,1, 32'hA00C, 32'h6020, 32'h9999, w2, {4{32'h8888_0008}}, 1, OWN_DCW, 32'h9990, 1);
    vecs[9]  = mk(1,1,1, 32'hA00C, 32'hC000, 32'hB000, w2, {4{32'h9999_0009}}, 1, OWN_IC,  32'hA000, 0);
    vecs[10] = mk(1,1,1, 32'hD000, 32'hC000, 32'hB000, w2, {4{32'hAAAA_000A}}, 4, OWN_DCW, 32'hB000, 1);
    vecs[11] = mk(1,1,0, 32'hD000, 32'hC000, 32'hB000, w2, {4{32'hBBBB_000B}}, 1, OWN_IC,  32'hD000, 0);
    vecs[12] = mk(0,1,0, 32'hD000, 32'hC000, 32'hB000, w2, {4{32'hCCCC_000C}}, 1, OWN_DCR, 32'hC000, 0);

    // Reset held with every request asserted
    reset = 1'b0; mem_ack = 1'b0; mem_data_in = '0;
    ic_read_req = 1; dc_read_req = 1; dc_write_req = 1;
    ic_read_addr = 32'h1234; dc_read_addr = 32'h200; dc_write_addr = 32'h100;
    dc_write_data = w1;
    repeat (2) tick();
    check("reset ctrl", 128'({mem_enable, mem_rw, ic_read_ack, dc_read_ack, dc_write_ack}), 128'(0));
    check("reset addr", 128'(mem_addr), 128'(0));
    check("reset wdata", mem_data_out, 128'(0));
    check("reset rdata", {ic_read_data[63:0], dc_read_data[63:0]}, 128'(0));
    $display("[TB] reset held 2 cycles, outputs idle");
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      ic_read_req = vecs[i].ic; dc_read_req = vecs[i].dcr; dc_write_req = vecs[i].dcw;
      ic_read_addr = vecs[i].ic_a; dc_read_addr = vecs[i].dcr_a;
      dc_write_addr = vecs[i].dcw_a; dc_write_data = vecs[i].wdata;
      do_txn($sformatf("vec%0d", i), vecs[i].own, vecs[i].exp_a, vecs[i].exp_rw,
             vecs[i].wdata, vecs[i].rdata, vecs[i].lat);
    end
    ic_read_req = 0; dc_read_req = 0; dc_write_req = 0;

    // mem_ack held into RESP, then a stray mem_ack in IDLE
    held = 128'h5A5A_0000_1111_2222_3333_4444_5555_6666;
    ic_read_req = 1; ic_read_addr = 32'hE008;
    tick();
    check("spur grant", 128'({mem_enable, mem_addr}), {95'd0, 1'b1, 32'hE000});
    mem_ack = 1; mem_data_in = held;
    tick();
    check("spur ack", 128'({ic_read_ack, dc_read_ack, dc_write_ack}), 128'(3'b100));
    ic_read_req = 0; mem_data_in = '1;
    tick();
    check("spur resp", 128'({ic_read_ack, dc_read_ack, dc_write_ack, mem_enable}), 128'(0));
    check("spur held", ic_read_data, held);
    repeat (2) tick();
    check("spur idle", 128'({ic_read_ack, dc_read_ack, dc_write_ack, mem_enable}), 128'(0));
    check("spur held2", ic_read_data, held);
    mem_ack = 0;
    tick();
    $display("[TB] spurious mem_ack in RESP/IDLE ignored");

    // Reset while a transaction is in MEM; late mem_ack must be ignored
    ic_read_req = 1; ic_read_addr = 32'hF000;
    tick();
    check("abort grant", 128'(mem_enable), 128'(1));
    reset = 0;
    tick();
    check("abort reset", 128'({mem_enable, mem_addr}), 128'(0));
    reset = 1; ic_read_req = 0; mem_ack = 1;
    tick();
    mem_ack = 0;
    check("abort late_ack", 128'({ic_read_ack, dc_read_ack, dc_write_ack, mem_enable}), 128'(0));
    tick();
    check("abort idle", 128'({ic_read_ack, dc_read_ack, dc_write_ack, mem_enable}), 128'(0));
    $display("[TB] reset mid-MEM abandons transaction");
    ic_read_req = 1; dc_read_req = 1; ic_read_addr = 32'h10; dc_read_addr = 32'h20;
    do_txn("post_reset_tie", OWN_IC, 32'h10, 0, '0, {4{32'h0F0F_0F0F}}, 1);

    // Randomized traffic against a request-level model
    ic_p = 0; dcr_p = 1; dcw_p = 0; last_d = 0;
    for (int n = 0; n < 60; n++) begin
      if (!ic_p && $urandom_range(0, 1) == 1) begin ic_p = 1; ic_read_addr = $urandom; end
      if (!dcr_p && $urandom_range(0, 1) == 1) begin dcr_p = 1; dc_read_addr = $urandom; end
      if (!dcw_p && $urandom_range(0, 2) == 0) begin
        dcw_p = 1; dc_write_addr = $urandom;
        dc_write_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!ic_p && !dcr_p && !dcw_p) begin ic_p = 1; ic_read_addr = $urandom; end
      ic_read_req = ic_p; dc_read_req = dcr_p; dc_write_req = dcw_p;
      pick_d = (dcr_p || dcw_p) && (!ic_p || !last_d);
      if (!pick_d) begin own = OWN_IC; ia = ic_read_addr; end
      else if (dcw_p) begin own = OWN_DCW; ia = dc_write_addr; end
      else begin own = OWN_DCR; ia = dc_read_addr; end
      ea = ia & ~32'hF;
      wd = dc_write_data;
      rd = {$urandom, $urandom, $urandom, $urandom};
      do_txn($sformatf("rnd%0d", n), own, ea, own == OWN_DCW, wd, rd, $urandom_range(1, 4));
      case (own)
        OWN_IC:  ic_p  = 0;
        OWN_DCR: dcr_p = 0;
        default: dcw_p = 0;
      endcase
      last_d = pick_d;
      ra = 0; wa = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the CPU's single external memory port between the I-cache line-refill channel and the D-cache refill/write-back channels. It sits directly downstream of the cpu top: cache miss requests in, and the mem_enable/mem_rw/mem_addr/mem_data/mem_ack bus out. It serialises one line transaction at a time, with round-robin fairness between the I-side and the D-side.

Parameters:
ADDR_W, 32, byte address width (matches REG_SIZE)
LINE_W, 128, cache line / memory data width in bits (matches WIDTH)
OFF_W, 4, line-offset bits (log2(LINE_W/8)); forced to zero on mem_addr

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
ic_read_req  in  1  I-cache line refill request, held until ic_read_ack
ic_read_addr  in  ADDR_W  I-cache refill address
ic_read_ack  out  1  one-cycle completion pulse to I-cache
ic_read_data  out  LINE_W  refill line, valid while ic_read_ack=1
dc_read_req  in  1  D-cache refill request, held until dc_read_ack
dc_read_addr  in  ADDR_W  D-cache refill address
dc_read_ack  out  1  one-cycle completion pulse
dc_read_data  out  LINE_W  refill line, valid while dc_read_ack=1
dc_write_req  in  1  D-cache write-back request, held until dc_write_ack
dc_write_addr  in  ADDR_W  write-back address
dc_write_data  in  LINE_W  write-back line
dc_write_ack  out  1  one-cycle completion pulse
mem_enable  out  1  memory transaction active
mem_rw  out  1  1 = write, 0 = read
mem_ack  in  1  memory completion, one cycle
mem_addr  out  ADDR_W  line-aligned address
mem_data_in  in  LINE_W  read data from memory, sampled on mem_ack
mem_data_out  out  LINE_W  write data to memory

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; all acks 0; mem_enable 0; mem_rw 0; mem_addr, mem_data_out, ic/dc_read_data all 0; last_grant = DSIDE, so the I-side wins the first tie.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - If any req is high, select a winner and latch its addr, write data, rw and owner. Then go to MEM with mem_enable=1.
  - The D-side internally gives dc_write_req priority over dc_read_req (eviction before refill).
  - Between the I-side and the D-side: round-robin. On a tie, the side not granted last wins; update last_grant.
- MEM:
  - mem_enable, mem_rw, mem_addr and mem_data_out are held stable.
  - On mem_ack=1: capture mem_data_in into the owner's read_data register (reads only), drop mem_enable, go to RESP.
  - Waits indefinitely for mem_ack; there is no timeout.
- RESP:
  - The owner's ack is high for exactly this one cycle; its read_data holds the captured line.
  - Next state is IDLE unconditionally; acks clear and read_data stays held.
  - The owner drops its req in the cycle after the ack. Because RESP always passes through IDLE, the same request is not re-granted.
- Latency: req first high in cycle 0 → mem_enable in cycle 1. mem_ack in cycle k (k ≥ 1) → owner ack in cycle k+1 → IDLE in cycle k+2. Minimum req-to-ack is 2 cycles; back-to-back grants are 3 cycles apart at minimum.
- mem_addr = latched addr with bits [OFF_W-1:0] forced to 0.
- mem_data_out is 0 for reads and the latched dc_write_data for writes.
- mem_ack while not in MEM: ignored.
- Requests arriving while not in IDLE: held by the requester and arbitrated at the next IDLE.
- Requester drops req mid-MEM: this is a protocol violation. The transaction completes and the ack still pulses.
- Reset mid-transaction: the transaction is abandoned, mem_enable=0 in the following cycle, and any late mem_ack is ignored.
- Simultaneous dc_write_req and dc_read_req: the write is served first and the read is deferred to the next D-side grant.

Decomposition:
- Shared package holds:
  - state enum {IDLE, MEM, RESP};
  - owner enum {OWN_IC, OWN_DCR, OWN_DCW};
  - side constants ISIDE/DSIDE;
  - MEM_RD=0, MEM_WR=1.
- Single module with no sub-modules. Winner selection is an always_comb block inside it.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all reqs high → all outputs 0, no mem_enable; release → I-side granted first, mem_addr=ic_read_addr aligned.
- I-refill: ic_read_req=1, ic_read_addr=0x0000_1234, memory acks 3 cycles after enable with 0xDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233 → mem_addr=0x0000_1230, mem_rw=0, ic_read_ack for one cycle with that data, total 5 cycles req→ack.
- Write-back precedes refill: dc_write_req and dc_read_req both high, addr 0x100/0x200 → first mem_rw=1 at 0x100 with dc_write_data, dc_write_ack; then mem_rw=0 at 0x200, dc_read_ack.
- Round-robin: ic_read_req and dc_read_req held continuously, ack latency 1 → grants alternate IC, DC, IC, DC; each ack is a single pulse, no double grant.
- Reset mid-MEM: reset=0 while mem_enable=1, then mem_ack pulses → no ack output, mem_enable=0 next cycle, IDLE.
- Spurious mem_ack in IDLE/RESP → no state change, no extra ack.
